// File: rtl/seq_pkg.sv
// Shared definitions for the sequence generator/detector pair: pattern table,
// pattern select type and generator states. GAP state exists only with SEQGEN_GAP_EN.
package seq_pkg;

  localparam int PAT_W = 5;

  typedef logic [1:0] seq_sel_t;

  // Vector bit 0 is the first bit on the line (table text is written bit0..bit4).
  localparam logic [PAT_W-1:0] SEQ_PAT [0:3] = '{
    5'b10001,
    5'b01110,
    5'b10101,
    5'b01111
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1
`ifdef SEQGEN_GAP_EN
    ,
    ST_GAP  = 2'd2
`endif
  } gen_state_t;

endpackage

// File: rtl/seq_pattern_rom.sv
// Combinational pattern select -> 5-bit pattern lookup, shared with the detector.
module seq_pattern_rom
  import seq_pkg::*;
(
  input  logic [1:0]       sel,
  output logic [PAT_W-1:0] pattern
);

  always_comb begin
    pattern = SEQ_PAT[sel];
  end

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a selected 5-bit pattern R times, LSB first.
// Optional idle gaps between repetitions when SEQGEN_GAP_EN is defined.
module sequence_generator
  import seq_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       lookfor_seq,
  input  logic [CNT_W-1:0] repeat_count,
`ifdef SEQGEN_GAP_EN
  input  logic [GAP_W-1:0] gap_len,
`endif
  output logic             serial_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_count
);

  gen_state_t       state;
  seq_sel_t         job_sel;
  seq_sel_t         rom_sel;
  logic [CNT_W-1:0] remaining;
  logic [2:0]       bit_idx;
  logic [2:0]       next_idx;
  logic [PAT_W-1:0] pattern;
`ifdef SEQGEN_GAP_EN
  logic [GAP_W-1:0] gap_cfg;
  logic [GAP_W-1:0] gap_cnt;
`endif

  // In IDLE the ROM looks at the live select so bit 0 can leave on the accepting edge.
  always_comb begin
    rom_sel  = (state == ST_IDLE) ? seq_sel_t'(lookfor_seq) : job_sel;
    next_idx = bit_idx + 3'd1;
  end

  seq_pattern_rom u_rom (
    .sel     (rom_sel),
    .pattern (pattern)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sent_count <= '0;
      job_sel    <= '0;
      remaining  <= '0;
      bit_idx    <= '0;
`ifdef SEQGEN_GAP_EN
      gap_cfg    <= '0;
      gap_cnt    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A start coinciding with the done cycle is dropped, not deferred.
          if (start && !done) begin
            if (repeat_count != '0) begin
              job_sel    <= seq_sel_t'(lookfor_seq);
              remaining  <= repeat_count;
              bit_idx    <= '0;
              busy       <= 1'b1;
              serial_out <= pattern[0];
              state      <= ST_SEND;
`ifdef SEQGEN_GAP_EN
              gap_cfg    <= gap_len;
`endif
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (bit_idx == 3'(PAT_W - 1)) begin
            sent_count <= sent_count + CNT_W'(1);
            remaining  <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state      <= ST_IDLE;
              done       <= 1'b1;
              busy       <= 1'b0;
              serial_out <= 1'b0;
            end
`ifdef SEQGEN_GAP_EN
            else if (gap_cfg != '0) begin
              state      <= ST_GAP;
              serial_out <= 1'b0;
              gap_cnt    <= gap_cfg - GAP_W'(1);
            end
`endif
            else begin
              bit_idx    <= '0;
              serial_out <= pattern[0];
            end
          end else begin
            bit_idx    <= next_idx;
            serial_out <= pattern[next_idx];
          end
        end
`ifdef SEQGEN_GAP_EN
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state      <= ST_SEND;
            bit_idx    <= '0;
            serial_out <= pattern[0];
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sequence_generator.md
# sequence_generator

Serial pattern transmitter paired with `sequence_detector`. On a start pulse it emits one of four fixed 5-bit patterns on a 1-bit line, first bit first, repeated a programmed number of times. Optional idle gaps separate repetitions. It drives the detector's `input_se` in system loopback and in the detector bench, and keeps a running count of patterns sent so the detector's `seq_count` can be checked against it.

## Interface
- `CNT_W`, 16, width of `repeat_count` and `sent_count`; matches the detector's `seq_count`.
- `GAP_W`, 4, width of `gap_len`.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request pulse; sampled only in IDLE.
- `lookfor_seq`  in  2  pattern select; same encoding as the detector.
- `repeat_count`  in  CNT_W  number of patterns to send; 0 is legal.
- `gap_len`  in  GAP_W  idle cycles between repetitions. Present only with `SEQGEN_GAP_EN`.
- `serial_out`  out  1  registered serial data; idle level 0.
- `busy`  out  1  high from the accepting edge until the done edge.
- `done`  out  1  one-cycle pulse at end of job.
- `sent_count`  out  CNT_W  cumulative complete patterns since reset.

## Operation
- Pattern table, bit 0 sent first, written bit0..bit4:
  - 0 = 10001
  - 1 = 01110
  - 2 = 10101
  - 3 = 11110
- States: IDLE, SEND, GAP.
- IDLE, `start`=1, `repeat_count`≠0:
  - Latch `lookfor_seq`, `repeat_count` and `gap_len`.
  - `bit_idx`←0, `busy`←1, `serial_out`←pattern bit 0, go SEND.
- IDLE, `start`=1, `repeat_count`=0: `done`←1 for one cycle, `busy` stays 0, no bits sent.
- SEND: each edge advances `bit_idx` and drives the next pattern bit. At the edge after bit 4 (the pattern-complete edge):
  - `sent_count`++ (wraps modulo 2^CNT_W) and the remaining count decrements.
  - If the count reaches 0: go IDLE, `done`←1, `busy`←0, `serial_out`←0.
  - Else if the latched gap is ≠0: go GAP, `serial_out`←0.
  - Else: stay in SEND, `bit_idx`←0, drive bit 0 of the next repetition.
- GAP: `serial_out`=0 for exactly the latched gap cycles, then SEND with bit 0.
- Latched job values are used for the whole job; input changes while busy have no effect.
- `start` while `busy` is ignored, not queued.
- `start` high on the done edge is ignored; a new job needs `start` in an IDLE cycle with `done`=0 or later.

## Timing
- Reset values: state IDLE, `serial_out`=0, `busy`=0, `done`=0, `sent_count`=0.
- Reset mid-job aborts at that edge. No `done`, and the partial pattern is not counted.
- Latency, taking the accepting edge as k:
  - Bit i of repetition r (r from 0, gap G) is valid after edge k + r·(5+G) + i.
  - Job length T = 5R + G(R−1). `done` is high after edge k+T for one cycle.
- `busy` is high from edge k to edge k+T.
- `sent_count` increments at each pattern-complete edge, one per repetition.
- `serial_out` is registered; no combinational path from any input.

## Configuration
- `SEQGEN_GAP_EN` defined: `gap_len` port, GAP state and gap counter exist.
- Not defined: G is fixed at 0. Patterns are sent back-to-back, and the port and GAP state are removed.

## Structure
- Shared package `seq_pkg`, used by both generator and detector:
  - `PAT_W`=5.
  - `SEQ_PAT[0:3]` constants.
  - `seq_sel_t` (2-bit).
  - Generator state enum.
- Sub-module `seq_pattern_rom`: combinational `seq_sel_t` → 5-bit pattern. Shared with the detector.

## Test plan
- Reset held 3 cycles → `serial_out`=0, `busy`=0, `sent_count`=0.
- `lookfor_seq`=0, `repeat_count`=2, G=0, start at edge k → bits 1000110001 on edges k..k+9; `done` after edge k+10; `sent_count`=2.
- `SEQGEN_GAP_EN`, sel=3, `repeat_count`=2, `gap_len`=3 → 11110,000,11110; `done` after k+13.
- `repeat_count`=0 → `done` pulse next cycle, `busy` never high, `sent_count` unchanged.
- `start` pulsed and `lookfor_seq` changed mid-job → no effect on the bit stream; a new job is accepted only after `done`.
- Reset asserted at bit 2 of sel=2 → `serial_out`=0 next cycle; `sent_count` not incremented; no `done`.
- Loopback into `sequence_detector`: `sent_count`=N → `seq_count`=N after `done`.
